regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port general register file with an integrated busy-bit scoreboard for the five-stage pipeline. Decode reads `NRD` operands per cycle and gets per-operand busy flags for hazard stalls. Execute/memory and writeback retire results through two independent write ports with same-cycle bypass. Decode marks a destination busy at issue, and the retiring write clears it.

## Interface
Parameters:
- `DATA_W`, 16, register width in bits
- `NREGS`, 8, number of registers (power of two)
- `ADDR_W`, 3, register address width; `2**ADDR_W == NREGS`
- `NRD`, 2, number of read ports (1..4)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `rd_addr`  in  NRD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- `rd_data`  out  NRD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
- `rd_busy`  out  NRD  port k operand has an outstanding producer
- `wa_en`, `wa_addr` (ADDR_W), `wa_data` (DATA_W), `wa_clr`  in  write port A; `wa_clr` = clear busy bit on write
- `wb_en`, `wb_addr` (ADDR_W), `wb_data` (DATA_W), `wb_clr`  in  write port B; same fields as port A
- `iss_en`  in  1  set busy for `iss_addr`
- `iss_addr`  in  ADDR_W  destination being issued
- `collide`  out  1  registered one-cycle pulse: A and B wrote the same address in the previous cycle

## Operation
- State consists of `regs[NREGS]` (DATA_W) and `busy[NREGS]` (1 bit).
- Writes happen at the rising edge when `rst`=1.
  - Port A writes `regs[wa_addr]` when `wa_en`=1; port B writes `regs[wb_addr]` when `wb_en`=1.
  - If both ports are enabled on the same address, B's data wins. `collide` is then 1 in the next cycle.
- Reads are combinational with bypass, per port k:
  - If `wb_en` and `wb_addr`==addr, return `wb_data`.
  - Otherwise, if `wa_en` and `wa_addr`==addr, return `wa_data`.
  - Otherwise, return `regs[addr]`.
  - Bypass is disabled while `rst`=0.
- The scoreboard updates at the rising edge, in priority order:
  - `busy[iss_addr]` is set by `iss_en`.
  - A busy bit is cleared by an enabled write with its `clr`=1.
  - If an issue and a clear target the same register in one cycle, the set wins (the new producer supersedes the old one).
- `rd_busy[k]` = `busy[addr]`, forced to 0 if a same-cycle enabled write with `clr`=1 targets addr.
  - A same-cycle `iss_en` does not raise `rd_busy`; the issuing instruction is younger than the reader.
- An issue to an already-busy register is legal. The bit stays set.
- Reset (`rst`=0 at the edge):
  - All `regs` = 0, all `busy` = 0, `collide` = 0.
  - Writes and issues presented in that cycle are discarded.
  - Reset mid-operation drops all outstanding busy state.

## Timing
- Read latency is 0 cycles (combinational). Write-to-array latency is 1 edge. Bypass makes a write visible to readers in the same cycle.
- Busy set by issue in cycle n is visible on `rd_busy` from cycle n+1.
- A clear in cycle n is visible combinationally in cycle n, and from the array from n+1.
- `collide` asserts in the cycle after the colliding edge, for 1 cycle.
- Reset values of outputs after the reset edge: `rd_data` = 0 for every address, `rd_busy` = 0, `collide` = 0.
- Addresses are full-range; no out-of-range case exists because NREGS = 2**ADDR_W.

## Configuration
- `REGFILE_ZERO_REG_EN` defined:
  - Register 0 is hardwired to zero. Writes to address 0 are ignored, including for bypass.
  - `busy[0]` is never set; reads of address 0 return 0 with `rd_busy`=0.
  - `collide` is not raised for address 0.
- Not defined: register 0 is an ordinary register, identical to all others.

## Test plan
- Reset then read all addresses: `rst`=0 for 1 edge, then sweep `rd_addr` 0..7 -> `rd_data`=0x0000, `rd_busy`=0 on every port.
- Write then bypass: `wa_en`=1, `wa_addr`=3, `wa_data`=0xBEEF with `rd_addr` port0=3 in the same cycle -> `rd_data`=0xBEEF in that cycle; after the edge, `regs[3]`=0xBEEF.
- Dual-write collision: A writes 5 with 0x1111 and B writes 5 with 0x2222 in the same cycle -> same-cycle read returns 0x2222, `regs[5]`=0x2222, `collide`=1 for exactly the next cycle.
- Scoreboard lifecycle:
  - `iss_en` on addr 2 -> `rd_busy`=1 from the next cycle.
  - `wb_en`, `wb_clr`=1 on addr 2, data 0x0042 -> `rd_busy`=0 and `rd_data`=0x0042 in the same cycle; busy stays 0 afterwards.
- Simultaneous issue and clear on addr 6 -> `busy[6]`=1 after the edge; `rd_busy` in the same cycle = 0.
- Mid-operation reset: registers 1 and 4 busy with data nonzero, `rst`=0 together with `wa_en` to 1 -> next cycle all `busy`=0, `regs`=0, write discarded.
  - With `REGFILE_ZERO_REG_EN` defined: writing 0xFFFF to addr 0 -> read returns 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass and a busy-bit scoreboard for hazard detection.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_sb #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wa_en,
  input  logic [ADDR_W-1:0]     wa_addr,
  input  logic [DATA_W-1:0]     wa_data,
  input  logic                  wa_clr,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  wb_clr,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  collide
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              collide_q, collide_d;

  logic wa_ok, wb_ok, iss_ok;
  logic wa_act, wb_act, iss_act;

`ifdef REGFILE_ZERO_REG_EN
  // Address 0 is a constant: its writes and issues never take effect anywhere.
  assign wa_ok  = (wa_addr != '0);
  assign wb_ok  = (wb_addr != '0);
  assign iss_ok = (iss_addr != '0);
`else
  assign wa_ok  = 1'b1;
  assign wb_ok  = 1'b1;
  assign iss_ok = 1'b1;
`endif

  assign wa_act  = rst & wa_en & wa_ok;
  assign wb_act  = rst & wb_en & wb_ok;
  assign iss_act = rst & iss_en & iss_ok;

  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    collide_d = wa_act & wb_act & (wa_addr == wb_addr);
    if (wa_act) regs_d[wa_addr] = wa_data;
    if (wb_act) regs_d[wb_addr] = wb_data;
    if (wa_act && wa_clr) busy_d[wa_addr] = 1'b0;
    if (wb_act && wb_clr) busy_d[wb_addr] = 1'b0;
    // Issue applied last so a new producer supersedes a same-cycle retire.
    if (iss_act) busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      collide_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      collide_q <= collide_d;
    end
  end

  assign collide = collide_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              a_hit, b_hit;

    assign addr  = rd_addr[k*ADDR_W +: ADDR_W];
    assign a_hit = wa_act & (wa_addr == addr);
    assign b_hit = wb_act & (wb_addr == addr);

    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = regs_q[addr];
      if (a_hit) rd_data[k*DATA_W +: DATA_W] = wa_data;
      if (b_hit) rd_data[k*DATA_W +: DATA_W] = wb_data;
      rd_busy[k] = busy_q[addr] & ~((a_hit & wa_clr) | (b_hit & wb_clr));
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expectations queued at stimulus time, popped and asserted
// once the combinational outputs have settled.
module tb_regfile_sb;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NRD    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wa_en, wa_clr, wb_en, wb_clr, iss_en;
  logic [ADDR_W-1:0]     wa_addr, wb_addr, iss_addr;
  logic [DATA_W-1:0]     wa_data, wb_data;
  logic                  collide;

  regfile_sb #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .ADDR_W(ADDR_W),
    .NRD   (NRD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wa_en   (wa_en),
    .wa_addr (wa_addr),
    .wa_data (wa_data),
    .wa_clr  (wa_clr),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .wb_clr  (wb_clr),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .collide (collide)
  );

  always #5 clk = ~clk;

  // kind: 0 = rd_data of port, 1 = rd_busy of port, 2 = collide
  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [15:0] exp;
  } exp_t;

  exp_t queue_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input int kind, input int port, input logic [15:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    queue_q.push_back(e);
  endtask

  task automatic exp_rd(input string tag, input int port, input logic [15:0] data,
                        input logic busy);
    push({tag, "_data"}, 0, port, data);
    push({tag, "_busy"}, 1, port, {15'd0, busy});
  endtask

  task automatic set_rd(input int port, input int addr);
    rd_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    #1;
    while (queue_q.size() > 0) begin
      e = queue_q.pop_front();
      case (e.kind)
        0:       obs = rd_data[e.port*DATA_W +: DATA_W];
        1:       obs = {15'd0, rd_busy[e.port]};
        default: obs = {15'd0, collide};
      endcase
      checks++;
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 1'b0; wa_clr = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_clr = 1'b0; wb_addr = '0; wb_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  initial begin
    rst     = 1'b0;
    rd_addr = '0;
    idle();
    step();
    rst = 1'b1;

    // Reset state across all addresses on both ports
    push("rst_collide", 2, 0, 16'd0);
    for (int a = 0; a < NREGS; a++) begin
      set_rd(0, a);
      set_rd(1, NREGS - 1 - a);
      exp_rd($sformatf("rst_p0_a%0d", a), 0, 16'h0000, 1'b0);
      exp_rd($sformatf("rst_p1_a%0d", NREGS - 1 - a), 1, 16'h0000, 1'b0);
      drain();
    end

    // Write with same-cycle bypass, then from the array
    set_rd(0, 3);
    set_rd(1, 0);
    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'hBEEF;
    exp_rd("byp_same", 0, 16'hBEEF, 1'b0);
    exp_rd("byp_other", 1, 16'h0000, 1'b0);
    drain();
    step();
    idle();
    exp_rd("wr_array", 0, 16'hBEEF, 1'b0);
    drain();

    // Dual-write collision: B wins, collide pulses for one cycle
    set_rd(0, 5);
    wa_en = 1'b1; wa_addr = 3'd5; wa_data = 16'h1111;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h2222;
    exp_rd("col_byp", 0, 16'h2222, 1'b0);
    push("col_pre", 2, 0, 16'd0);
    drain();
    step();
    idle();
    exp_rd("col_array", 0, 16'h2222, 1'b0);
    push("col_pulse", 2, 0, 16'd1);
    drain();
    step();
    push("col_drop", 2, 0, 16'd0);
    drain();

    // Scoreboard lifecycle on register 2
    set_rd(0, 2);
    iss_en = 1'b1; iss_addr = 3'd2;
    exp_rd("iss_same", 0, 16'h0000, 1'b0);
    drain();
    step();
    idle();
    exp_rd("iss_next", 0, 16'h0000, 1'b1);
    drain();
    wb_en = 1'b1; wb_clr = 1'b1; wb_addr = 3'd2; wb_data = 16'h0042;
    exp_rd("clr_same", 0, 16'h0042, 1'b0);
    drain();
    step();
    idle();
    exp_rd("clr_after", 0, 16'h0042, 1'b0);
    drain();
    step();
    exp_rd("clr_stays", 0, 16'h0042, 1'b0);
    drain();

    // Simultaneous issue and clear on register 6: set wins
    set_rd(0, 6);
    iss_en = 1'b1; iss_addr = 3'd6;
    wa_en = 1'b1; wa_clr = 1'b1; wa_addr = 3'd6; wa_data = 16'h0606;
    exp_rd("isclr_same", 0, 16'h0606, 1'b0);
    drain();
    step();
    idle();
    exp_rd("isclr_next", 0, 16'h0606, 1'b1);
    drain();

    // Mid-operation reset with registers 1 and 4 busy and nonzero
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h1234;
    iss_en = 1'b1; iss_addr = 3'd1;
    step();
    wb_addr = 3'd4; wb_data = 16'h4444;
    iss_addr = 3'd4;
    step();
    idle();
    set_rd(0, 1);
    set_rd(1, 4);
    exp_rd("pre_rst_r1", 0, 16'h1234, 1'b1);
    exp_rd("pre_rst_r4", 1, 16'h4444, 1'b1);
    drain();
    rst = 1'b0;
    wa_en = 1'b1; wa_addr = 3'd1; wa_data = 16'h7777;
    exp_rd("rst_no_byp", 0, 16'h1234, 1'b1);
    drain();
    step();
    rst = 1'b1;
    idle();
    for (int a = 0; a < NREGS; a++) begin
      set_rd(0, a);
      exp_rd($sformatf("mid_rst_a%0d", a), 0, 16'h0000, 1'b0);
      drain();
    end

    // Register 0 behaviour depends on build option
    set_rd(0, 0);
    wa_en = 1'b1; wa_addr = 3'd0; wa_data = 16'hFFFF;
`ifdef REGFILE_ZERO_REG_EN
    exp_rd("zero_byp", 0, 16'h0000, 1'b0);
`else
    exp_rd("zero_byp", 0, 16'hFFFF, 1'b0);
`endif
    drain();
    step();
    idle();
`ifdef REGFILE_ZERO_REG_EN
    exp_rd("zero_array", 0, 16'h0000, 1'b0);
`else
    exp_rd("zero_array", 0, 16'hFFFF, 1'b0);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
